// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the 32x8 single-port data memory (CPU vs host/loader),
// registered fixed priority with a bounded CPU streak. Optional host_lock: DMEM_ARB_HOST_LOCK_EN.
module dmem_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_BITS  = 5,
  parameter int HOLD_MAX   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef DMEM_ARB_HOST_LOCK_EN
  input  logic                  host_lock,
`endif
  input  logic                  cpu_req,
  input  logic                  cpu_w_r,
  input  logic [ADDR_BITS-1:0]  cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_gnt,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_valid,
  input  logic                  host_req,
  input  logic                  host_w_r,
  input  logic [ADDR_BITS-1:0]  host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  output logic                  host_gnt,
  output logic [DATA_WIDTH-1:0] host_rdata,
  output logic                  host_valid,
  output logic                  mem_en,
  output logic                  mem_w_r,
  output logic [ADDR_BITS-1:0]  mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic [1:0]            dbg_state
);

  // Handshake: a requester holds req/w_r/addr/wdata until it sees its one-cycle gnt;
  // req still high in the cycle after gnt is a fresh access. Read data arrives with a
  // one-cycle x_valid pulse the cycle after the grant; writes produce no valid pulse.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    G_CPU  = 2'd1,
    G_HOST = 2'd2
  } state_e;

  localparam logic [3:0] HOLD_LIM = 4'(HOLD_MAX);

  state_e                  state_q, state_d;
  logic [3:0]              streak_q, streak_d;
  logic                    mem_en_q, mem_en_d;
  logic                    mem_w_r_q, mem_w_r_d;
  logic [ADDR_BITS-1:0]    mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
  logic                    pend_cpu_q, pend_host_q;
  logic [DATA_WIDTH-1:0]   cpu_rdata_q, host_rdata_q;
  logic                    lock_w;

`ifdef DMEM_ARB_HOST_LOCK_EN
  assign lock_w = host_lock;
`else
  assign lock_w = 1'b0;
`endif

  always_comb begin
    state_d  = IDLE;
    streak_d = 4'd0;
    if (lock_w) begin
      // Host owns the memory; a waiting CPU request simply stays pending.
      if (host_req) state_d = G_HOST;
    end else if (cpu_req && host_req) begin
      if (streak_q >= HOLD_LIM) begin
        state_d = G_HOST;
      end else begin
        state_d  = G_CPU;
        streak_d = streak_q + 4'd1;
      end
    end else if (cpu_req) begin
      state_d = G_CPU;
    end else if (host_req) begin
      state_d = G_HOST;
    end
  end

  always_comb begin
    mem_en_d    = 1'b0;
    mem_w_r_d   = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    case (state_d)
      G_CPU: begin
        mem_en_d    = 1'b1;
        mem_w_r_d   = cpu_w_r;
        mem_addr_d  = cpu_addr;
        mem_wdata_d = cpu_wdata;
      end
      G_HOST: begin
        mem_en_d    = 1'b1;
        mem_w_r_d   = host_w_r;
        mem_addr_d  = host_addr;
        mem_wdata_d = host_wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      streak_q     <= 4'd0;
      mem_en_q     <= 1'b0;
      mem_w_r_q    <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      pend_cpu_q   <= 1'b0;
      pend_host_q  <= 1'b0;
      cpu_rdata_q  <= '0;
      host_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      mem_en_q    <= mem_en_d;
      mem_w_r_q   <= mem_w_r_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      pend_cpu_q  <= (state_q == G_CPU) && !mem_w_r_q;
      pend_host_q <= (state_q == G_HOST) && !mem_w_r_q;
      if (pend_cpu_q)  cpu_rdata_q  <= mem_rdata;
      if (pend_host_q) host_rdata_q <= mem_rdata;
    end
  end

  // Read data is presented straight from the memory in its valid cycle, then held.
  assign cpu_rdata  = pend_cpu_q  ? mem_rdata : cpu_rdata_q;
  assign host_rdata = pend_host_q ? mem_rdata : host_rdata_q;
  assign cpu_valid  = pend_cpu_q;
  assign host_valid = pend_host_q;
  assign cpu_gnt    = (state_q == G_CPU);
  assign host_gnt   = (state_q == G_HOST);
  assign mem_en     = mem_en_q;
  assign mem_w_r    = mem_w_r_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign busy       = mem_en_q | pend_cpu_q | pend_host_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized traffic checked each
// cycle against a transaction-level model of the arbitration and memory rules.
module tb_dmem_arbiter;
  localparam int DW = 8;
  localparam int AW = 5;
  localparam int HM = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cpu_req = 1'b0, cpu_w_r = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          host_req = 1'b0, host_w_r = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic [DW-1:0] host_wdata = '0;
  logic          cpu_gnt, cpu_valid, host_gnt, host_valid;
  logic [DW-1:0] cpu_rdata, host_rdata;
  logic          mem_en, mem_w_r, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [1:0]    dbg_state;
`ifdef DMEM_ARB_HOST_LOCK_EN
  logic          host_lock = 1'b0;
  logic          lock_next = 1'b0;
`endif

  dmem_arbiter #(.DATA_WIDTH(DW), .ADDR_BITS(AW), .HOLD_MAX(HM)) dut (
    .clk(clk), .rst(rst),
`ifdef DMEM_ARB_HOST_LOCK_EN
    .host_lock(host_lock),
`endif
    .cpu_req(cpu_req), .cpu_w_r(cpu_w_r), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rdata(cpu_rdata), .cpu_valid(cpu_valid),
    .host_req(host_req), .host_w_r(host_w_r), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rdata(host_rdata), .host_valid(host_valid),
    .mem_en(mem_en), .mem_w_r(mem_w_r), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .dbg_state(dbg_state)
  );

  // clock / reset / memory
  always #5 clk = ~clk;

  logic [DW-1:0] mem [32];
  logic          load_en = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [DW-1:0] load_data = '0;

  always @(posedge clk) begin
    if (load_en) mem[load_addr] <= load_data;
    else if (mem_en) begin
      if (mem_w_r) mem[mem_addr] <= mem_wdata;
      else         mem_rdata <= mem[mem_addr];
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // scoreboard / reference model
  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] ref_mem [32];
  logic [DW:0]   exp_q[$];
  logic          e_cgnt = 0, e_hgnt = 0, e_en = 0, e_wr = 0, e_cval = 0, e_hval = 0;
  logic [AW-1:0] e_addr = '0;
  logic [DW-1:0] e_wdata = '0, e_crd = '0, e_hrd = '0;
  int            host_wait_run = 0;

  logic [13:0]   cpu_ops[$], host_ops[$];
  int            cpu_rate = 0, host_rate = 0;
  logic          rand_rst = 0, rst_on_cpu_gnt = 0, log_en = 0;
  logic [1:0]    glog[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic predict();
    logic [DW:0] ent;
    logic        nc, nh, lk;
    if (e_en && e_wr)  ref_mem[e_addr] = e_wdata;
    if (e_en && !e_wr) exp_q.push_back({e_hgnt, ref_mem[e_addr]});
    lk = 1'b0;
`ifdef DMEM_ARB_HOST_LOCK_EN
    lk = host_lock;
`endif
    if (rst) begin
      exp_q.delete();
      {e_cgnt, e_hgnt, e_en, e_wr, e_cval, e_hval} = '0;
      e_addr = '0; e_wdata = '0; e_crd = '0; e_hrd = '0;
      host_wait_run = 0;
    end else begin
      e_cval = 1'b0;
      e_hval = 1'b0;
      if (exp_q.size() > 0) begin
        ent = exp_q.pop_front();
        if (ent[DW]) begin e_hval = 1'b1; e_hrd = ent[DW-1:0]; end
        else         begin e_cval = 1'b1; e_crd = ent[DW-1:0]; end
      end
      // Host is owed the slot once it has watched HM CPU grants in a row.
      nh = host_req && (lk || !cpu_req || host_wait_run >= HM);
      nc = cpu_req && !nh && !lk;
      host_wait_run = (nc && host_req) ? host_wait_run + 1 : 0;
      e_cgnt  = nc;
      e_hgnt  = nh;
      e_en    = nc | nh;
      e_wr    = nc ? cpu_w_r   : (nh ? host_w_r   : 1'b0);
      e_addr  = nc ? cpu_addr  : (nh ? host_addr  : '0);
      e_wdata = nc ? cpu_wdata : (nh ? host_wdata : '0);
    end
  endtask

  // driver tasks
  task automatic step();
    logic [13:0] op;
    @(negedge clk);
    check("cpu_gnt", cpu_gnt, e_cgnt);
    check("host_gnt", host_gnt, e_hgnt);
    check("mem_en", mem_en, e_en);
    check("mem_w_r", mem_w_r, e_wr);
    check("mem_addr", mem_addr, e_addr);
    check("mem_wdata", mem_wdata, e_wdata);
    check("cpu_valid", cpu_valid, e_cval);
    check("host_valid", host_valid, e_hval);
    check("cpu_rdata", cpu_rdata, e_crd);
    check("host_rdata", host_rdata, e_hrd);
    check("busy", busy, e_en | e_cval | e_hval);
    check("dbg_state", dbg_state, e_cgnt ? 2'd1 : (e_hgnt ? 2'd2 : 2'd0));
    if (log_en) glog.push_back({host_gnt, cpu_gnt});
    rst = 1'b0;
    if (rand_rst && $urandom_range(39) == 0) rst = 1'b1;
    if (rst_on_cpu_gnt && cpu_gnt) begin rst = 1'b1; rst_on_cpu_gnt = 1'b0; end
`ifdef DMEM_ARB_HOST_LOCK_EN
    host_lock = lock_next;
`endif
    if (!cpu_req || cpu_gnt) begin
      if (cpu_ops.size() > 0) begin
        op = cpu_ops.pop_front();
        cpu_req = 1'b1;
        {cpu_w_r, cpu_addr, cpu_wdata} = op;
      end else if ($urandom_range(99) < cpu_rate) begin
        cpu_req = 1'b1;
        cpu_w_r = 1'($urandom_range(1));
        cpu_addr = 5'($urandom_range(31));
        cpu_wdata = 8'($urandom_range(255));
      end else cpu_req = 1'b0;
    end
    if (!host_req || host_gnt) begin
      if (host_ops.size() > 0) begin
        op = host_ops.pop_front();
        host_req = 1'b1;
        {host_w_r, host_addr, host_wdata} = op;
      end else if ($urandom_range(99) < host_rate) begin
        host_req = 1'b1;
        host_w_r = 1'($urandom_range(1));
        host_addr = 5'($urandom_range(31));
        host_wdata = 8'($urandom_range(255));
      end else host_req = 1'b0;
    end
    predict();
  endtask

  task automatic drain();
    logic done;
    done = 1'b0;
    cpu_rate = 0; host_rate = 0; rand_rst = 1'b0;
`ifdef DMEM_ARB_HOST_LOCK_EN
    lock_next = 1'b0;
`endif
    for (int i = 0; i < 40 && !done; i++) begin
      step();
      if (!cpu_req && !host_req && !busy && !cpu_gnt && !host_gnt) done = 1'b1;
    end
    check("drain_done", done, 1);
    step();
  endtask

  initial begin
    load_en = 1'b1;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      load_addr = 5'(i);
      load_data = (i == 5) ? 8'h3C : 8'($urandom_range(255));
      ref_mem[i] = load_data;
    end
    @(negedge clk);
    load_en = 1'b0;

    // reset state, then leave reset
    step();
    check("rst_busy", busy, 0);
    step(); step();

    // CPU read of addr 5
    cpu_ops.push_back({1'b0, 5'd5, 8'h00});
    step();
    step();
    check("t1_cpu_gnt", cpu_gnt, 1);
    check("t1_host_gnt", host_gnt, 0);
    step();
    check("t1_cpu_valid", cpu_valid, 1);
    check("t1_cpu_rdata", cpu_rdata, 8'h3C);
    check("t1_host_quiet", {host_gnt, host_valid, host_rdata}, 0);
    drain();

    // host write 0xA5 to 31, then read back
    host_ops.push_back({1'b1, 5'd31, 8'hA5});
    host_ops.push_back({1'b0, 5'd31, 8'h00});
    step();
    step();
    check("t2_wr_gnt", host_gnt, 1);
    check("t2_wr_strobe", mem_w_r, 1);
    check("t2_wr_addr", mem_addr, 31);
    check("t2_wr_data", mem_wdata, 8'hA5);
    step();
    check("t2_rd_gnt", host_gnt, 1);
    check("t2_rd_strobe", mem_w_r, 0);
    step();
    check("t2_host_valid", host_valid, 1);
    check("t2_host_rdata", host_rdata, 8'hA5);
    drain();

    // host alone, three back-to-back accesses
    for (int i = 0; i < 3; i++)
      host_ops.push_back({1'($urandom_range(1)), 5'($urandom_range(31)), 8'($urandom_range(255))});
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      check("t5_host_gnt", host_gnt, 1);
      check("t5_state", dbg_state, 2);
    end
    drain();

    // both requesting continuously
    glog.delete();
    cpu_rate = 100; host_rate = 100;
    step();
    log_en = 1'b1;
    repeat (20) step();
    log_en = 1'b0;
    for (int i = 0; i < 20; i++)
      check("t3_pattern", glog[i], (i % 5 == 4) ? 2'b10 : 2'b01);
    drain();

    // reset while a CPU read is in flight
    cpu_ops.push_back({1'b0, 5'd7, 8'h00});
    rst_on_cpu_gnt = 1'b1;
    step();
    step();
    check("t4_cpu_gnt", cpu_gnt, 1);
    step();
    check("t4_all_zero", {cpu_gnt, cpu_valid, cpu_rdata, host_gnt, host_valid, host_rdata,
                          mem_en, mem_w_r, mem_addr, mem_wdata, busy}, 0);
    step();
    check("t4_no_valid", cpu_valid, 0);
    drain();

`ifdef DMEM_ARB_HOST_LOCK_EN
    glog.delete();
    lock_next = 1'b1;
    cpu_rate = 100; host_rate = 100;
    step();
    log_en = 1'b1;
    repeat (9) step();
    lock_next = 1'b0;
    step();
    log_en = 1'b0;
    for (int i = 0; i < 10; i++) check("t6_lock_host", glog[i], 2'b10);
    step();
    check("t6_release_cpu", cpu_gnt, 1);
    drain();
`endif

    // randomized traffic
    for (int c = 0; c < 10; c++) begin
      cpu_rate  = $urandom_range(100);
      host_rate = $urandom_range(100);
      rand_rst  = 1'b1;
`ifdef DMEM_ARB_HOST_LOCK_EN
      lock_next = ($urandom_range(3) == 0);
`endif
      repeat (60) step();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
